serial_universal_subtractor: RTL and testbench

Bit-serial companion to the combinational universal adder. It computes the reverse operation, `A - B - op`, one bit per clock, LSB first. A start/busy/done handshake wraps the computation. Its result and borrow format mirror the adder's sum and carry, so the adder's directed vectors can be replayed in the subtract direction on the same stimulus style.

---
 rtl/serial_universal_subtractor_if.sv | 30 +++
 rtl/serial_universal_subtractor.sv | 107 ++++++++++
 tb/tb_serial_universal_subtractor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/serial_universal_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_universal_subtractor_if
// Brief    : Start/busy/done handshake and operand/result bus for the
//            bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_universal_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             borrow;

  modport master (
    output start, A, B, op,
    input  busy, done, D, borrow
  );

  modport slave (
    input  start, A, B, op,
    output busy, done, D, borrow
  );
endinterface
`default_nettype wire

// File: rtl/serial_universal_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_universal_subtractor
// Brief    : Computes A - B - op one bit per clock, LSB first, behind a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_universal_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_universal_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bin;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;

  logic             w_ai;
  logic             w_bi;
  logic             w_dbit;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  // Operands shift right, so the bit under process is always at index 0.
  assign w_ai       = r_a[0];
  assign w_bi       = r_b[0];
  assign w_dbit     = w_ai ^ w_bi ^ r_bin;
  assign w_bout     = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bin);
  assign w_res_next = {w_dbit, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_bin   <= bus.op;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_bin <= w_bout;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST_BIT) begin
            r_d      <= w_res_next;
            r_borrow <= w_bout;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.D      = r_d;
  assign bus.borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_universal_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_universal_subtractor
// Brief    : Directed and exhaustive scoreboard bench for the serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_universal_subtractor;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  int tests;
  int fails;
  int n_issued;
  int n_done;
  logic [WIDTH-1:0] last_d;
  logic             last_b;
  logic [WIDTH:0]   sb_q[$];

  serial_universal_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_universal_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (!rst) chk("busy_done_exclusive", 32'(bus.busy & bus.done), 32'd0);
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("D", 32'(bus.D), 32'(e[WIDTH:1]));
        chk("borrow", 32'(bus.borrow), 32'(e[0]));
      end
    end
  end

  // Runs one operation at maximum rate: accept edge, WIDTH shift edges, DONE edge.
  task automatic issue(input int a, input int b, input int op, input bit scramble);
    int t;
    logic [WIDTH-1:0] ed;
    logic             eb;
    t  = a - b - op;
    ed = t[WIDTH-1:0];
    eb = (a < b + op);
    bus.A     = WIDTH'(a);
    bus.B     = WIDTH'(b);
    bus.op    = op[0];
    bus.start = 1'b1;
    sb_q.push_back({ed, eb});
    n_issued++;
    @(posedge clk); #1;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("D_hold_accept", 32'(bus.D), 32'(last_d));
    if (scramble) begin
      bus.A = '1;
      bus.B = '0;
    end
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk); #1;
      if (k < WIDTH) begin
        chk("busy_shift", 32'(bus.busy), 32'd1);
        chk("D_hold_shift", 32'(bus.D), 32'(last_d));
        chk("borrow_hold_shift", 32'(bus.borrow), 32'(last_b));
      end else begin
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("done_pulse", 32'(bus.done), 32'd1);
      end
    end
    @(posedge clk); #1;
    chk("done_fall", 32'(bus.done), 32'd0);
    chk("idle_not_busy", 32'(bus.busy), 32'd0);
    chk("D_held_after", 32'(bus.D), 32'(ed));
    last_d = ed;
    last_b = eb;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; n_issued = 0; n_done = 0;
    last_d = '0; last_b = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.op = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_D", 32'(bus.D), 32'd0);
    chk("rst_borrow", 32'(bus.borrow), 32'd0);

    issue(5, 3, 0, 1'b0);
    issue(7, 6, 1, 1'b0);
    issue(9, 8, 0, 1'b0);
    issue(8, 9, 0, 1'b0);
    issue(4, 4, 1, 1'b0);
    issue(0, 15, 1, 1'b0);
    issue(5, 3, 0, 1'b1);
    bus.start = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset lands on E2 of an in-flight 8-9 subtraction.
    bus.A = 4'd8; bus.B = 4'd9; bus.op = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_D", 32'(bus.D), 32'd0);
    chk("midrst_borrow", 32'(bus.borrow), 32'd0);
    last_d = '0; last_b = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("midrst_no_done", 32'(n_done), 32'(n_issued));
    issue(5, 3, 0, 1'b0);

    for (int op = 0; op < 2; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          issue(a, b, op, 1'b0);

    bus.start = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_issued));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
